i2c_passthru_wordrx: RTL and testbench

//  Parametrised successor to the single-bit passthru receiver. Receives 1..N_BITS_MAX consecutive bits from master or slave side.

---
 rtl/i2c_passthru_pkg.sv | 10 +
 rtl/i2c_passthru_fref_timer.sv | 28 ++
 rtl/i2c_passthru_wordrx.sv | 148 ++++++++++++++
 tb/tb_i2c_passthru_wordrx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/i2c_passthru_pkg.sv
// i2c_passthru_pkg: shared state encoding, default tick constants and width helper for the passthru receivers
package i2c_passthru_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOW, S_RELEASE, S_HIGH, S_HOLD, S_FIN, S_ABORT} state_t;
  localparam int T_LOW_DEF = 20;
  localparam int T_HIGH_DEF = 16;
  localparam int T_TIMEOUT_DEF = 255;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/i2c_passthru_fref_timer.sv
// i2c_passthru_fref_timer: f_ref rising-edge tick counter, cleared by load, stops at target (tc = terminal count)
//   clk, rst : clock, async active-high reset
//   f_ref    : timing reference synchronous to clk
//   load     : restart count from zero
//   target   : terminal count, compared directly (no wrap)
//   tc       : count has reached target
module i2c_passthru_fref_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         f_ref,
  input  logic         load,
  input  logic [W-1:0] target,
  output logic         tc
);
  logic         f_q;
  logic [W-1:0] cnt;
  assign tc = cnt == target;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f_q <= 1'b0;
      cnt <= '0;
    end else begin
      f_q <= f_ref;
      cnt <= load ? '0 : (f_ref && !f_q && !tc) ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/i2c_passthru_wordrx.sv
// i2c_passthru_wordrx: paced I2C word receiver driving its own SCL, assembling 1..N_BITS_MAX bits MSB first
//   i_clk, i_rst       : clock, async active-high reset
//   i_f_ref            : tick reference for SCL low/high/timeout timing
//   i_start_rx         : start a word (side and bit count sampled with it)
//   i_rx_frm_slv       : 1 = slave side, 0 = master side (START/STOP aborts)
//   i_n_bits           : bits per word; 0 or > N_BITS_MAX means N_BITS_MAX
//   i_tx_done          : opposite side forwarded the current bit
//   i_scl, i_sda       : synchronised receive-side bus lines
//   o_rx_data          : received bits, left-aligned at bit N_BITS_MAX-1
//   o_rx_bit_cnt       : completed bits; o_rx_bit_done pulses per bit
//   o_rx_sda_*         : per-bit SDA observations; o_rx_done / o_violation word status
//   o_scl, o_sda       : bus drive (1 = released); SDA is never driven
// Optional: I2C_PASSTHRU_TIMEOUT_EN bounds the wait for i_scl after releasing SCL.
module i2c_passthru_wordrx
  import i2c_passthru_pkg::*;
#(
  parameter int N_BITS_MAX            = 9,
  parameter int WIDTH_N_BITS          = 4,
  parameter int F_REF_T_LOW           = T_LOW_DEF,
  parameter int WIDTH_F_REF_T_LOW     = 5,
  parameter int F_REF_T_HIGH          = T_HIGH_DEF,
  parameter int WIDTH_F_REF_T_HIGH    = 5,
  parameter int F_REF_T_TIMEOUT       = T_TIMEOUT_DEF,
  parameter int WIDTH_F_REF_T_TIMEOUT = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_f_ref,
  input  logic                    i_start_rx,
  input  logic                    i_rx_frm_slv,
  input  logic [WIDTH_N_BITS-1:0] i_n_bits,
  input  logic                    i_tx_done,
  input  logic                    i_scl,
  input  logic                    i_sda,
  output logic [N_BITS_MAX-1:0]   o_rx_data,
  output logic [WIDTH_N_BITS-1:0] o_rx_bit_cnt,
  output logic                    o_rx_sda_init_valid,
  output logic                    o_rx_sda_init,
  output logic                    o_rx_sda_mid_change,
  output logic                    o_rx_sda_final,
  output logic                    o_scl,
  output logic                    o_sda,
  output logic                    o_rx_bit_done,
  output logic                    o_rx_done,
  output logic                    o_violation
);
  localparam int TW = max3(WIDTH_F_REF_T_LOW, WIDTH_F_REF_T_HIGH, WIDTH_F_REF_T_TIMEOUT);
  state_t                  state, state_n;
  logic                    side_slv, start, mid_abort, timeout, scl_n, tc, load, bit_end;
  logic [WIDTH_N_BITS-1:0] n_bits;
  logic [TW-1:0]           tgt;
  assign o_sda = 1'b1;
  assign load = state_n != state;
  assign bit_end = state == S_HIGH && state_n == S_HOLD;
  assign tgt = state == S_LOW ? TW'(F_REF_T_LOW) : state == S_HIGH ? TW'(F_REF_T_HIGH) : TW'(F_REF_T_TIMEOUT);
  i2c_passthru_fref_timer #(.W(TW)) u_timer (
    .clk(i_clk), .rst(i_rst), .f_ref(i_f_ref), .load(load), .target(tgt), .tc(tc)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    start = 1'b0;
    mid_abort = 1'b0;
    timeout = 1'b0;
    case (state)
      S_IDLE, S_FIN, S_ABORT: if (i_start_rx) begin
        start = 1'b1;
        state_n = S_LOW;
      end
      S_LOW: if (tc) state_n = S_RELEASE;
      S_RELEASE: begin
        if (i_scl) state_n = S_HIGH;
`ifdef I2C_PASSTHRU_TIMEOUT_EN
        else if (tc) begin
          timeout = 1'b1;
          state_n = S_ABORT;
        end
`endif
      end
      S_HIGH: if (!side_slv && i_sda != o_rx_sda_init) begin
        mid_abort = 1'b1;
        state_n = S_ABORT;
      end else if (tc) state_n = S_HOLD;
      S_HOLD: if (i_tx_done) state_n = o_rx_bit_cnt == n_bits ? S_FIN : S_LOW;
      default: state_n = S_IDLE;
    endcase
    // FIN keeps SCL as HOLD left it (low): the bus stays stretched until the next word
    scl_n = (state_n == S_LOW || state_n == S_HOLD || mid_abort) ? 1'b0 :
            (state_n == S_RELEASE || state_n == S_HIGH || timeout) ? 1'b1 : o_scl;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      side_slv <= 1'b0;
      n_bits <= '0;
      o_rx_data <= '0;
      o_rx_bit_cnt <= '0;
      o_rx_sda_init_valid <= 1'b0;
      o_rx_sda_init <= 1'b0;
      o_rx_sda_mid_change <= 1'b0;
      o_rx_sda_final <= 1'b0;
      o_scl <= 1'b1;
      o_rx_bit_done <= 1'b0;
      o_rx_done <= 1'b0;
      o_violation <= 1'b0;
    end else begin
      o_scl <= scl_n;
      o_rx_bit_done <= bit_end;
      if (start) begin
        side_slv <= i_rx_frm_slv;
        n_bits <= (i_n_bits == '0 || i_n_bits > WIDTH_N_BITS'(N_BITS_MAX)) ? WIDTH_N_BITS'(N_BITS_MAX) : i_n_bits;
        o_rx_data <= '0;
        o_rx_bit_cnt <= '0;
        o_rx_sda_init_valid <= 1'b0;
        o_rx_sda_init <= 1'b0;
        o_rx_sda_mid_change <= 1'b0;
        o_rx_sda_final <= 1'b0;
        o_rx_done <= 1'b0;
        o_violation <= 1'b0;
      end
      if (state == S_RELEASE && i_scl) begin
        o_rx_sda_init_valid <= 1'b1;
        o_rx_sda_init <= i_sda;
      end
      // slave-side SDA change or SCL dropping before the high time elapsed
      if (state == S_HIGH && ((side_slv && i_sda != o_rx_sda_init) || (!i_scl && !tc))) o_violation <= 1'b1;
      if (mid_abort) begin
        o_rx_sda_mid_change <= 1'b1;
        o_rx_done <= 1'b1;
      end
      if (timeout) begin
        o_violation <= 1'b1;
        o_rx_done <= 1'b1;
      end
      // bits land left-aligned: bit k of the word goes to position N_BITS_MAX-1-k
      if (bit_end) begin
        o_rx_sda_final <= i_sda;
        o_rx_data <= o_rx_data | ({o_rx_sda_init, {(N_BITS_MAX-1){1'b0}}} >> o_rx_bit_cnt);
        o_rx_bit_cnt <= o_rx_bit_cnt + 1'b1;
      end
      if (state == S_HOLD && i_tx_done) begin
        o_rx_sda_init_valid <= 1'b0;
        o_rx_sda_mid_change <= 1'b0;
        if (state_n == S_FIN) o_rx_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_i2c_passthru_wordrx.sv
// tb_i2c_passthru_wordrx: directed + random words against a pattern-level model of the received word
`define WAIT_FOR(c, t) begin int w_ = 0; while (!(c) && w_ < 20000) begin @(negedge clk); w_++; end chk({"wait_", t}, 32'(w_ < 20000), 1); end
module tb_i2c_passthru_wordrx;
  logic       clk = 1'b0, f_ref = 1'b0, rst, start_rx, frm_slv, tx_done, scl, sda, scl_stuck;
  logic [3:0] n_bits;
  logic [8:0] rx_data;
  logic [3:0] bit_cnt;
  logic       init_valid, init, mid_change, sda_final, o_scl, o_sda, bit_done, rx_done, violation;
  int         total = 0, bad = 0, nbd = 0, cyc = 0;
  logic [8:0] pat;
  // clk period 10 units stands for 62.5 ns (16 MHz); f_ref period 40 units = 4 MHz, offset from clk edges
  always #5 clk = ~clk;
  initial begin
    #3;
    forever #20 f_ref = ~f_ref;
  end
  assign scl = o_scl & ~scl_stuck;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bit_done) nbd++;
  i2c_passthru_wordrx dut (
    .i_clk(clk), .i_rst(rst), .i_f_ref(f_ref), .i_start_rx(start_rx), .i_rx_frm_slv(frm_slv),
    .i_n_bits(n_bits), .i_tx_done(tx_done), .i_scl(scl), .i_sda(sda),
    .o_rx_data(rx_data), .o_rx_bit_cnt(bit_cnt), .o_rx_sda_init_valid(init_valid), .o_rx_sda_init(init),
    .o_rx_sda_mid_change(mid_change), .o_rx_sda_final(sda_final), .o_scl(o_scl), .o_sda(o_sda),
    .o_rx_bit_done(bit_done), .o_rx_done(rx_done), .o_violation(violation)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk(tag, 32'({o_scl, o_sda, rx_data, bit_cnt, init_valid, init, mid_change, sda_final, bit_done, rx_done, violation}),
        32'({2'b11, 20'b0}));
  endtask
  task automatic pulse_start(input logic slv, input logic [3:0] nb);
    frm_slv = slv;
    n_bits = nb;
    start_rx = 1'b1;
    @(negedge clk);
    start_rx = 1'b0;
  endtask
  // gl: bit index whose SDA toggles while SCL is high (-1 none); low: check SCL low 4..6 us (64..96 cycles)
  // stall: hold i_tx_done low for 10 us after bit 0
  task automatic run_word(input logic slv, input logic [3:0] nb, input logic [8:0] p, input int gl,
                          input bit low, input bit stall);
    int en, nbd0, tf, n;
    logic [8:0] exp_d;
    en = (nb == 0 || nb > 9) ? 9 : int'(nb);
    nbd0 = nbd;
    pulse_start(slv, nb);
    chk("start_clr", 32'({rx_done, violation, bit_cnt, rx_data}), 0);
    for (int k = 0; k < en; k++) begin
      `WAIT_FOR(o_scl == 1'b0, "fall")
      tf = cyc;
      sda = p[8-k];
      `WAIT_FOR(o_scl == 1'b1, "rise")
      if (low) chk("t_low", 32'((cyc - tf) >= 64 && (cyc - tf) <= 96), 1);
      if (gl == k) begin
        repeat (20) @(negedge clk);
        sda = ~sda;
        if (!slv) begin
          repeat (3) @(negedge clk);
          exp_d = (p >> (9 - k)) << (9 - k);
          chk("abort_mid", 32'(mid_change), 1);
          chk("abort_done", 32'(rx_done), 1);
          chk("abort_cnt", 32'(bit_cnt), k);
          chk("abort_viol", 32'(violation), 0);
          chk("abort_scl", 32'(o_scl), 0);
          chk("abort_data", 32'(rx_data), 32'(exp_d));
          return;
        end
      end
      if (stall && k == 0) begin
        `WAIT_FOR(bit_done == 1'b1, "bd")
        n = 0;
        repeat (160) begin
          @(negedge clk);
          n += int'(o_scl);
        end
        chk("stall_scl", n, 0);
        chk("stall_cnt", 32'(bit_cnt), 1);
        tx_done = 1'b1;
      end
    end
    `WAIT_FOR(rx_done == 1'b1, "done")
    exp_d = (p >> (9 - en)) << (9 - en);
    chk("data", 32'(rx_data), 32'(exp_d));
    chk("cnt", 32'(bit_cnt), en);
    chk("n_bit_done", nbd - nbd0, en);
    chk("viol", 32'(violation), 32'(slv && gl >= 0));
    chk("mid", 32'(mid_change), 0);
  endtask
  initial begin
    rst = 1'b1;
    start_rx = 1'b0;
    frm_slv = 1'b0;
    n_bits = 4'd0;
    tx_done = 1'b1;
    sda = 1'b1;
    scl_stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    run_word(1'b1, 4'd8, {8'hA5, 1'b0}, -1, 1'b1, 1'b0);
    pat = 9'($urandom);
    pat[6] = 1'b1;
    run_word(1'b0, 4'd9, pat, 2, 1'b0, 1'b0);
    run_word(1'b1, 4'($urandom_range(1, 9)), 9'($urandom), 0, 1'b0, 1'b0);
    run_word(1'b1, 4'd5, 9'($urandom), -1, 1'b0, 1'b0);
    tx_done = 1'b0;
    run_word(1'b0, 4'd4, 9'($urandom), -1, 1'b1, 1'b1);
    repeat (4) run_word(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 9'($urandom), -1, 1'b0, 1'b0);
    scl_stuck = 1'b1;
    pulse_start(1'b1, 4'd1);
    repeat (1300) @(negedge clk);
`ifdef I2C_PASSTHRU_TIMEOUT_EN
    chk("tmo_done", 32'(rx_done), 1);
    chk("tmo_viol", 32'(violation), 1);
`else
    chk("tmo_done", 32'(rx_done), 0);
    chk("tmo_viol", 32'(violation), 0);
`endif
    chk("tmo_scl", 32'(o_scl), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    scl_stuck = 1'b0;
    @(negedge clk);
    sda = 1'($urandom);
    pulse_start(1'b1, 4'd9);
    `WAIT_FOR(bit_cnt == 4'd4, "cnt4")
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("rst_async");
    @(negedge clk);
    chk_reset("rst_edge");
    rst = 1'b0;
    @(negedge clk);
    run_word(1'($urandom_range(0, 1)), 4'd0, 9'($urandom), -1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
